// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: finds word alignment from control-token
// runs, then decodes each symbol to pixel data, data enable and control bits.
module tmds_decoder #(
    parameter int CTRL_RUN      = 16,
    parameter int SEARCH_CYCLES = 64,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [9:0] raw_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] c_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int SRCH_W = $clog2(SEARCH_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(CTRL_RUN);
    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(LOSS_CYCLES);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t             r_state, w_state_nxt;
    logic [9:0]         r_prev, r_sym;
    logic [3:0]         r_offset, w_offset_nxt, w_offset_inc;
    logic [RUN_W-1:0]   r_run, w_run_nxt;
    logic [SRCH_W-1:0]  r_search, w_search_nxt;
    logic [LOSS_W-1:0]  r_loss, w_loss_nxt;
    logic               r_skip, w_skip_nxt;
    logic [7:0]         r_data;
    logic               r_de, r_locked;
    logic [1:0]         r_c;

    logic [19:0]        w_hist;
    logic [9:0]         w_sym_nxt;
    logic               w_tok;
    logic [1:0]         w_cbits;
    logic [8:0]         w_q;
    logic [7:0]         w_d;

    // Window into the two most recent words; offset counts bits into the older word.
    assign w_hist    = {raw_i, r_prev};
    assign w_sym_nxt = 10'(w_hist >> r_offset);

    always_comb begin
        w_tok   = 1'b1;
        w_cbits = 2'b00;
        case (r_sym)
            10'h354: w_cbits = 2'b00;
            10'h0AB: w_cbits = 2'b01;
            10'h154: w_cbits = 2'b10;
            10'h2AB: w_cbits = 2'b11;
            default: w_tok   = 1'b0;
        endcase
    end

    always_comb begin
        w_q    = r_sym[9] ? {r_sym[8], ~r_sym[7:0]} : r_sym[8:0];
        w_d    = 8'h00;
        w_d[0] = w_q[0];
        for (int i = 1; i < 8; i++)
            w_d[i] = w_q[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end

    assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_search_nxt = r_search;
        w_loss_nxt   = r_loss;
        w_offset_nxt = r_offset;
        w_skip_nxt   = 1'b0;
        case (r_state)
            S_SEARCH: begin
                // r_skip marks the symbol sliced with the previous offset.
                if (r_skip || !w_tok)
                    w_run_nxt = '0;
                else if (r_run != RUN_LOCK)
                    w_run_nxt = r_run + 1'b1;
                if (r_search != SRCH_LAST)
                    w_search_nxt = r_search + 1'b1;
                if (w_run_nxt == RUN_LOCK) begin
                    w_state_nxt  = S_LOCKED;
                    w_run_nxt    = '0;
                    w_search_nxt = '0;
                    w_loss_nxt   = '0;
                end else if (r_search == SRCH_LAST) begin
                    w_offset_nxt = w_offset_inc;
                    w_run_nxt    = '0;
                    w_search_nxt = '0;
                    w_skip_nxt   = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_tok)
                    w_loss_nxt = '0;
                else if (r_loss != LOSS_MAX)
                    w_loss_nxt = r_loss + 1'b1;
                if (w_loss_nxt == LOSS_MAX) begin
                    w_state_nxt  = S_SEARCH;
                    w_offset_nxt = w_offset_inc;
                    w_run_nxt    = '0;
                    w_search_nxt = '0;
                    w_loss_nxt   = '0;
                    w_skip_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_SEARCH;
            r_run    <= '0;
            r_search <= '0;
            r_loss   <= '0;
            r_offset <= 4'd0;
            r_skip   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_search <= w_search_nxt;
            r_loss   <= w_loss_nxt;
            r_offset <= w_offset_nxt;
            r_skip   <= w_skip_nxt;
        end
    end

    // Outputs follow the next state so lock and unlock act on the deciding edge.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_prev   <= 10'd0;
            r_sym    <= 10'd0;
            r_data   <= 8'h00;
            r_de     <= 1'b0;
            r_c      <= 2'b00;
            r_locked <= 1'b0;
        end else begin
            r_prev   <= raw_i;
            r_sym    <= w_sym_nxt;
            r_locked <= (w_state_nxt == S_LOCKED);
            if (w_state_nxt == S_LOCKED) begin
                if (w_tok) begin
                    r_de <= 1'b0;
                    r_c  <= w_cbits;
                end else begin
                    r_de   <= 1'b1;
                    r_data <= w_d;
                end
            end else begin
                r_de   <= 1'b0;
                r_data <= 8'h00;
                r_c    <= 2'b00;
            end
        end
    end

    assign data_o   = r_data;
    assign de_o     = r_de;
    assign c_o      = r_c;
    assign locked_o = r_locked;
    assign offset_o = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed token/data streams at several
// bit rotations, with a monitor checking decoded bytes, timing and control bits.
module tb_tmds_decoder;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [9:0] raw_i = 10'd0;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] c_o;
    logic       locked_o;
    logic [3:0] offset_o;

    tmds_decoder dut (
        .clk      (clk),
        .reset_i  (reset_i),
        .raw_i    (raw_i),
        .data_o   (data_o),
        .de_o     (de_o),
        .c_o      (c_o),
        .locked_o (locked_o),
        .offset_o (offset_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0AB;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2AB;

    typedef struct {
        logic [7:0] b;
        int         due;
    } dexp_t;

    dexp_t      dq[$];
    logic [1:0] cq[$];
    int         checks = 0;
    int         errors = 0;
    int         rot = 0;
    logic [9:0] prev_sym = 10'd0;
    logic [1:0] c_prev = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference TMDS encoder (transition minimisation plus simple inversion choice).
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [8:0] qm;
        logic       xn;
        xn    = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
        qm    = 9'd0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        if ($countones(qm[7:0]) > 4)
            return {1'b1, qm[8], ~qm[7:0]};
        return {1'b0, qm[8], qm[7:0]};
    endfunction

    // Serialise symbols and re-cut them into words that lead the symbol grid by rot bits.
    task automatic send_sym(input logic [9:0] s);
        logic [19:0] t;
        t        = {s, prev_sym};
        raw_i    = 10'(t >> (10 - rot));
        prev_sym = s;
        @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] b, input bit push);
        dexp_t e;
        if (push) begin
            e.b   = b;
            e.due = cyc + 3;
            dq.push_back(e);
        end
        send_sym(enc(b));
    endtask

    task automatic send_toks(input logic [9:0] t, input int n);
        for (int i = 0; i < n; i++) send_sym(t);
    endtask

    task automatic hard_reset();
        raw_i    = 10'd0;
        prev_sym = 10'd0;
        reset_i  = 1'b1;
        @(negedge clk);
        reset_i  = 1'b0;
    endtask

    task automatic wait_lock(input int bound, output int n);
        n = 0;
        while (!locked_o && n < bound) begin
            send_sym(TOK0);
            n++;
        end
    endtask

    // Monitor: pops expected bytes on de_o and expected control codes on c_o changes.
    initial begin
        dexp_t e;
        forever begin
            @(negedge clk);
            if (de_o) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL de_unexpected data %02h at cycle %0d, none expected", data_o, cyc);
                end else begin
                    e = dq.pop_front();
                    if (data_o !== e.b || cyc != e.due) begin
                        errors++;
                        $display("FAIL data got %02h at cycle %0d expected %02h at cycle %0d",
                                 data_o, cyc, e.b, e.due);
                    end
                end
            end
            if (c_o !== c_prev) begin
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("FAIL c_unexpected got %b was %b", c_o, c_prev);
                end else if (c_o !== cq.pop_front()) begin
                    errors++;
                    $display("FAIL c_order got %b", c_o);
                end
                c_prev = c_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int drop;
        #1 reset_i = 1'b1;
        #2;
        chk("rst_data", data_o, 0);
        chk("rst_de", de_o, 0);
        chk("rst_c", c_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_offset", offset_o, 0);
        @(negedge clk);
        reset_i = 1'b0;

        // Rotation 3: search reaches offset 3 at cycle 192, stale symbol, 16 tokens.
        rot = 3;
        wait_lock(4 * 64 + 40, n);
        chk("t1_lock_cycle", n, 209);
        chk("t1_locked", locked_o, 1);
        chk("t1_offset", offset_o, 3);
        send_toks(TOK0, 40);
        for (int i = 0; i < 800; i++) send_data(8'((i * 7 + 3) & 255), 1'b1);
        send_toks(TOK0, 20);

        // Asynchronous reset while locked, then relock at the same offset.
        #2 reset_i = 1'b1;
        raw_i    = 10'd0;
        prev_sym = 10'd0;
        #1;
        chk("ar_data", data_o, 0);
        chk("ar_de", de_o, 0);
        chk("ar_c", c_o, 0);
        chk("ar_locked", locked_o, 0);
        chk("ar_offset", offset_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        wait_lock(4 * 64 + 40, n);
        chk("ar_relock_cycle", n, 209);
        chk("ar_relock_offset", offset_o, 3);
        send_toks(TOK0, 20);

        // Rotation 0: all four control tokens in order and boundary data bytes.
        hard_reset();
        rot = 0;
        wait_lock(4 * 64 + 40, n);
        chk("t2_lock_cycle", n, 18);
        chk("t2_offset", offset_o, 0);
        cq.push_back(2'b01); send_toks(TOK1, 3);
        cq.push_back(2'b10); send_toks(TOK2, 3);
        cq.push_back(2'b11); send_toks(TOK3, 3);
        send_data(8'h00, 1'b1);
        send_data(8'hFF, 1'b1);
        send_data(8'h55, 1'b1);
        send_data(8'hA5, 1'b1);
        cq.push_back(2'b00); send_toks(TOK0, 20);

        // Runs of 15 tokens never lock; offset walks every 64 cycles and wraps.
        hard_reset();
        rot = 0;
        for (int k = 1; k <= 640; k++) begin
            if ((k - 1) % 20 < 15) send_sym(TOK0);
            else send_data(8'(k & 255), 1'b0);
            if (k % 64 == 0 || k % 64 == 63) begin
                chk($sformatf("t4_offset_%0d", k), offset_o, (k / 64) % 10);
                chk($sformatf("t4_unlocked_%0d", k), locked_o, 0);
            end
        end

        // 16th token lands on the search-timer expiry cycle: lock wins.
        hard_reset();
        rot = 0;
        for (int k = 1; k <= 64; k++) begin
            if (k <= 46) send_data(8'(k * 3), 1'b0);
            else send_sym(TOK0);
            if (k == 63) begin
                chk("t5_pre_locked", locked_o, 0);
                chk("t5_pre_offset", offset_o, 0);
            end
        end
        chk("t5_locked", locked_o, 1);
        chk("t5_offset", offset_o, 0);
        send_toks(TOK0, 20);

        // Rotation 9: lock, then loss of tokens drops lock at count 4096.
        hard_reset();
        rot = 9;
        wait_lock(10 * 64 + 40, n);
        chk("t3_lock_cycle", n, 593);
        chk("t3_offset", offset_o, 9);
        send_toks(TOK0, 20);
        drop = 0;
        for (int k = 1; k <= 5000; k++) begin
            send_data(8'((k * 13 + 1) & 255), k <= 4095);
            if (!locked_o && drop == 0) begin
                drop = k;
                chk("t3_drop_offset", offset_o, 0);
            end
        end
        chk("t3_drop_cycle", drop, 4098);
        chk("t3_end_unlocked", locked_o, 0);

        chk("dq_drained", dq.size(), 0);
        chk("cq_drained", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
